// File: rtl/mod_reduce_512_seq.sv
// mod_reduce_512_seq: bit-serial restoring modular reducer.
// It consumes a 2*N_BITS product MSB first, one bit per clock, and returns
// the product mod MODULUS. Each step doubles the residue, brings in the next
// product bit and applies at most one conditional subtract. A single
// N_BITS+2-wide subtractor carries the whole datapath.
module mod_reduce_512_seq #(
  parameter int unsigned         N_BITS  = 256,
  parameter logic [N_BITS-1:0]   MODULUS = 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*N_BITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_BITS-1:0]     out_data,
  output logic                  busy
);

  localparam int unsigned       CNT_W    = $clog2(2 * N_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(2 * N_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                state_q,     state_d;
  logic [2*N_BITS-1:0]   shift_q,     shift_d;
  logic [N_BITS-1:0]     r_q,         r_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [N_BITS-1:0]     out_data_q,  out_data_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q,      busy_d;

  // One restoring step: t = 2*r + bit is always below 2*MODULUS, so one
  // conditional subtract is enough to bring it back into [0, MODULUS).
  // The borrow out of the subtractor doubles as the t >= MODULUS compare.
  function automatic logic [N_BITS-1:0] cond_sub(input logic [N_BITS:0] t);
    logic [N_BITS+1:0] sub;
    sub = {1'b0, t} - {2'b00, MODULUS};
    if (sub[N_BITS+1]) begin
      cond_sub = N_BITS'(t);
    end else begin
      cond_sub = N_BITS'(sub);
    end
  endfunction

  // Next-state and datapath logic; the handshake outputs are derived from
  // the next state so that they leave the block straight from flops.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          shift_d = in_data;
          r_d     = '0;
          cnt_d   = CNT_LAST;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r_d     = cond_sub({r_q, shift_q[2*N_BITS-1]});
        shift_d = {shift_q[2*N_BITS-2:0], 1'b0};
        if (cnt_q == '0) begin
          out_data_d = r_d;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers; asynchronous reset drops any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mod_reduce_512_seq.sv
// Testbench for mod_reduce_512_seq: directed and random operands checked
// against an arithmetic reference (x % MODULUS), including latency,
// backpressure, mid-run reset and back-to-back traffic.
module tb_mod_reduce_512_seq;

  localparam logic [255:0] MOD  = 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [511:0] MODW = {256'd0, MOD};

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  mod_reduce_512_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] model(input logic [511:0] x);
    logic [511:0] q;
    q = x % MODW;
    return q[255:0];
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full operation with out_ready held high; checks latency, busy, result
  // and the return to IDLE after the handshake.
  task automatic run_op(input logic [511:0] x, input string tag);
    logic [255:0] exp;
    int           k;
    bit           busy_ok;
    exp       = model(x);
    out_ready = 1'b1;
    chk({tag, "_rdy"}, 512'(in_ready), 512'(1));
    in_data  = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = rnd512();
    busy_ok  = 1'b1;
    k        = 0;
    while (!out_valid && k < 600) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      tick();
      k++;
    end
    chk({tag, "_lat"}, 512'(k), 512'(512));
    chk({tag, "_busy"}, 512'(busy_ok), 512'(1));
    chk({tag, "_data"}, 512'(out_data), 512'(exp));
    tick();
    chk({tag, "_idle"}, 512'({out_valid, in_ready, busy}), 512'(3'b010));
  endtask

  logic [511:0] ops[8];
  logic [255:0] got_q[$];
  logic [511:0] x;
  logic [255:0] d0;
  bit           stable;
  bit           seen;
  int           k;
  int           idx;
  int           cyc;
  bit           acc;

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #2 rst_n  = 1'b0;
    tick();
    tick();
    chk("rst_flags", 512'({out_valid, in_ready, busy}), 512'(3'b010));
    chk("rst_data", 512'(out_data), 512'(0));
    rst_n = 1'b1;
    tick();

    // Directed corner operands
    run_op(512'd0, "zero");
    run_op(MODW + 512'd5, "mod_p5");
    run_op(MODW, "mod");
    run_op(MODW - 512'd1, "mod_m1");
    x = (MODW - 512'd1) * (MODW - 512'd1);
    chk("sq_model", 512'(model(x)), 512'(1));
    run_op(x, "sq");
    run_op({512{1'b1}}, "allones");

    // Backpressure: hold the result for 20 cycles with a stray in_valid pulse
    x         = rnd512();
    out_ready = 1'b0;
    in_data   = x;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 600) begin
      tick();
      k++;
    end
    chk("bp_lat", 512'(k), 512'(512));
    d0     = out_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid = 1'b1;
        in_data  = rnd512();
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_data !== d0 || !out_valid || in_ready || !busy) stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_stable", 512'(stable), 512'(1));
    chk("bp_data", 512'(d0), 512'(model(x)));
    out_ready = 1'b1;
    tick();
    chk("bp_release", 512'({out_valid, in_ready, busy}), 512'(3'b010));
    run_op(rnd512(), "after_bp");

    // Reset in the middle of a run
    in_data  = rnd512();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 100; i++) tick();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_flags", 512'({out_valid, in_ready, busy}), 512'(3'b010));
    chk("mrst_data", 512'(out_data), 512'(0));
    tick();
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (out_valid || busy) seen = 1'b1;
    end
    chk("mrst_no_out", 512'(seen), 512'(0));
    run_op(rnd512(), "after_rst");

    // Back-to-back with in_valid held and random out_ready
    for (int i = 0; i < 8; i++) ops[i] = rnd512();
    idx      = 0;
    cyc      = 0;
    in_data  = ops[0];
    in_valid = 1'b1;
    while (got_q.size() < 8 && cyc < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got_q.push_back(out_data);
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 8) in_data = ops[idx];
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_count", 512'(got_q.size()), 512'(8));
    chk("b2b_quiet", 512'({out_valid, busy}), 512'(0));
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) chk($sformatf("b2b_%0d", i), 512'(got_q[i]), 512'(model(ops[i])));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
